// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - handshake bundle between fetch, imm_gen_stage and decode
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) ();
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      instr_o;
  logic [TAG_W-1:0] tag_o;
  logic [XLEN-1:0]  imm_o;
  logic [2:0]       fmt_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  modport master (
    output flush_i, in_valid_i, instr_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, tag_o, imm_o, fmt_o, illegal_o, illegal_cnt_o
  );

  modport slave (
    input  flush_i, in_valid_i, instr_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, tag_o, imm_o, fmt_o, illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - immediate classification/generation with main+skid buffering
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  imm_gen_stage_if.slave bus
);
  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_SH   = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6,
    FMT_ILL  = 3'd7
  } fmt_e;

  logic [31:0]     w;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            sh_ok;
  fmt_e            new_fmt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] new_imm;

  always_comb begin
    w      = bus.instr_i;
    opcode = w[6:0];
    f3     = w[14:12];
    if (XLEN == 64) begin
      sh_ok = (w[31:26] == 6'b000000) || ((w[31:26] == 6'b010000) && (f3 == 3'b101));
    end else begin
      sh_ok = (w[31:25] == 7'b0000000) || ((w[31:25] == 7'b0100000) && (f3 == 3'b101));
    end

    new_fmt = FMT_ILL;
    case (opcode)
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) new_fmt = sh_ok ? FMT_SH : FMT_ILL;
        else                              new_fmt = FMT_I;
      end
      7'b0000011: new_fmt = FMT_I;
      7'b1100111: new_fmt = (f3 == 3'b000) ? FMT_I : FMT_ILL;
      7'b0100011: new_fmt = FMT_S;
      7'b1100011: new_fmt = FMT_B;
      7'b0110111,
      7'b0010111: new_fmt = FMT_U;
      7'b1101111: new_fmt = FMT_J;
      7'b0110011: new_fmt = FMT_NONE;
      default:    new_fmt = FMT_ILL;
    endcase

    // Every format fits a 32-bit signed value; widen once at the end.
    imm32 = 32'd0;
    case (new_fmt)
      FMT_I:   imm32 = {{20{w[31]}}, w[31:20]};
      FMT_SH:  imm32 = (XLEN == 64) ? {26'd0, w[25:20]} : {27'd0, w[24:20]};
      FMT_S:   imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   imm32 = {w[31:12], 12'd0};
      FMT_J:   imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
    new_imm = XLEN'($signed(imm32));
  end

  logic             main_valid, skid_valid;
  logic [31:0]      main_instr, skid_instr;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic [XLEN-1:0]  main_imm, skid_imm;
  logic [2:0]       main_fmt, skid_fmt;
  logic [CNT_W-1:0] cnt;
  logic             accept, out_hs, main_free;

  assign accept    = bus.in_valid_i && !skid_valid && !bus.flush_i;
  assign out_hs    = main_valid && bus.out_ready_i;
  assign main_free = !main_valid || out_hs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_instr <= '0;
      main_tag   <= '0;
      main_imm   <= '0;
      main_fmt   <= '0;
      skid_instr <= '0;
      skid_tag   <= '0;
      skid_imm   <= '0;
      skid_fmt   <= '0;
      cnt        <= '0;
    end else begin
      // A delivery during a flush still counts toward the illegal total.
      if (out_hs && (main_fmt == FMT_ILL) && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
      if (bus.flush_i) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (out_hs && skid_valid) begin
        main_instr <= skid_instr;
        main_tag   <= skid_tag;
        main_imm   <= skid_imm;
        main_fmt   <= skid_fmt;
        skid_valid <= 1'b0;
      end else if (accept && main_free) begin
        main_valid <= 1'b1;
        main_instr <= bus.instr_i;
        main_tag   <= bus.tag_i;
        main_imm   <= new_imm;
        main_fmt   <= new_fmt;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_instr <= bus.instr_i;
        skid_tag   <= bus.tag_i;
        skid_imm   <= new_imm;
        skid_fmt   <= new_fmt;
      end else if (out_hs) begin
        main_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o    = !skid_valid;
  assign bus.out_valid_o   = main_valid;
  assign bus.instr_o       = main_instr;
  assign bus.tag_o         = main_tag;
  assign bus.imm_o         = main_imm;
  assign bus.fmt_o         = main_fmt;
  assign bus.illegal_o     = (main_fmt == FMT_ILL);
  assign bus.illegal_cnt_o = cnt;
endmodule
